// File: rtl/qc_pkg.sv
// Shared types for the gate sequencer: opcodes, error codes, FSM states,
// the microcode word layout and the decoder's classification result.
package qc_pkg;

  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_H         = 4'd1,
    OP_X         = 4'd2,
    OP_Z         = 4'd3,
    OP_CNOT      = 4'd4,
    OP_CPHASE    = 4'd5,
    OP_SWAP      = 4'd6,
    OP_MASKPHASE = 4'd7,
    OP_END       = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_OPCODE  = 2'd1,
    ERR_RANGE   = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_EXEC = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    KIND_EXEC      = 3'd0,
    KIND_NOP       = 3'd1,
    KIND_END       = 3'd2,
    KIND_ILLEGAL   = 3'd3,
    KIND_RANGE_ERR = 3'd4
  } kind_e;

  typedef struct packed {
    opcode_e     op;
    logic [3:0]  qa;
    logic [3:0]  qb;
    logic [15:0] imm;
    logic [3:0]  rsvd;
  } instr_t;

endpackage

// File: rtl/gate_decoder.sv
// Combinational classification of one microcode word: executable gate,
// NOP, END, illegal opcode, or qubit-index fault.
module gate_decoder
  import qc_pkg::*;
#(
  parameter int MAX_QUBITS = 4
) (
  input  instr_t instr,
  output kind_e  kind
);

  // Mask/value bits that address qubits beyond the register are forbidden.
  localparam logic [3:0] HI_MASK = (MAX_QUBITS >= 4) ? 4'h0
                                 : 4'(~((32'd1 << MAX_QUBITS) - 32'd1));

  function automatic logic q_ok(input logic [3:0] q);
    return int'({28'd0, q}) < MAX_QUBITS;
  endfunction

  logic unused_fields;
  assign unused_fields = ^{instr.imm, instr.rsvd};

  always_comb begin
    kind = KIND_ILLEGAL;
    case (instr.op)
      OP_NOP: kind = KIND_NOP;
      OP_END: kind = KIND_END;
      OP_H, OP_X, OP_Z:
        kind = q_ok(instr.qa) ? KIND_EXEC : KIND_RANGE_ERR;
      OP_CNOT, OP_CPHASE, OP_SWAP:
        kind = (q_ok(instr.qa) && q_ok(instr.qb) && (instr.qa != instr.qb))
               ? KIND_EXEC : KIND_RANGE_ERR;
      OP_MASKPHASE:
        kind = (((instr.qa | instr.qb) & HI_MASK) == 4'h0)
               ? KIND_EXEC : KIND_RANGE_ERR;
      default: kind = KIND_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/gate_sequencer.sv
// Microcode-driven gate sequencer: fetches words from an external ROM,
// issues gate commands with a valid/ready handshake and waits for execution.
module gate_sequencer
  import qc_pkg::*;
#(
  parameter int MAX_QUBITS = 4,
  parameter int PC_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      prog_id,
  input  logic            abort,
  output logic [2:0]      rom_prog_id,
  output logic [PC_W-1:0] rom_addr,
  input  logic [31:0]     rom_data,
  output logic            gate_valid,
  input  logic            gate_ready,
  output logic [3:0]      gate_op,
  output logic [3:0]      gate_qa,
  output logic [3:0]      gate_qb,
  output logic [15:0]     gate_imm,
  input  logic            exec_done,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [7:0]      gate_count
);

  state_e          state, state_nx;
  logic [PC_W-1:0] pc;
  logic [2:0]      prog_q;
  instr_t          ir;
  instr_t          rom_instr;
  kind_e           kind;
  logic [7:0]      count_q;
  logic            err_q;
  err_code_e       err_code_q;
  err_code_e       err_code_nx;
  logic            pc_step;
  logic            accept;
  logic            pc_last;
  logic            unused_bits;

  assign rom_instr   = instr_t'(rom_data);
  assign pc_last     = &pc;
  assign unused_bits = ^ir.rsvd;

  gate_decoder #(.MAX_QUBITS(MAX_QUBITS)) u_decoder (
    .instr (rom_instr),
    .kind  (kind)
  );

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    err_code_nx = ERR_NONE;
    pc_step     = 1'b0;
    accept      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nx = ST_FETCH;
      ST_FETCH: begin
        if (abort) state_nx = ST_IDLE;
        else begin
          case (kind)
            KIND_END: state_nx = ST_DONE;
            KIND_NOP: begin
              if (pc_last) begin
                state_nx    = ST_ERROR;
                err_code_nx = ERR_OVERRUN;
              end else pc_step = 1'b1;
            end
            KIND_ILLEGAL: begin
              state_nx    = ST_ERROR;
              err_code_nx = ERR_OPCODE;
            end
            KIND_RANGE_ERR: begin
              state_nx    = ST_ERROR;
              err_code_nx = ERR_RANGE;
            end
            default: state_nx = ST_ISSUE;
          endcase
        end
      end
      ST_ISSUE: begin
        if (abort) state_nx = ST_IDLE;
        else if (gate_ready) begin
          state_nx = ST_WAIT_EXEC;
          accept   = 1'b1;
        end
      end
      ST_WAIT_EXEC: begin
        if (abort) state_nx = ST_IDLE;
        else if (exec_done) begin
          if (pc_last) begin
            state_nx    = ST_ERROR;
            err_code_nx = ERR_OVERRUN;
          end else begin
            state_nx = ST_FETCH;
            pc_step  = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= '0;
      prog_q     <= '0;
      ir         <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) begin
        prog_q     <= prog_id;
        pc         <= '0;
        count_q    <= '0;
        err_q      <= 1'b0;
        err_code_q <= ERR_NONE;
      end
      if (pc_step) pc <= pc + 1'b1;
      if (state == ST_FETCH) ir <= rom_instr;
      if (accept && count_q != 8'hFF) count_q <= count_q + 8'd1;
      if (state_nx == ST_ERROR) begin
        err_q      <= 1'b1;
        err_code_q <= err_code_nx;
      end
    end
  end

  assign rom_prog_id = prog_q;
  assign rom_addr    = pc;
  assign gate_valid  = (state == ST_ISSUE);
  assign gate_op     = ir.op;
  assign gate_qa     = ir.qa;
  assign gate_qb     = ir.qb;
  assign gate_imm    = ir.imm;
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign gate_count  = count_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// Self-checking bench for gate_sequencer: table-driven program runs, hand
// sequences for latency/abort/reset corners, and randomized programs.
module tb_gate_sequencer;

  localparam int MAXQ   = 4;
  localparam int BUDGET = 2000;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  qa;
    logic [3:0]  qb;
    logic [15:0] imm;
  } gate_t;

  typedef struct {
    int pid, stall_idx, stall_len, exec_lat, abort_gate;
    int exp_gates, exp_done, exp_code, exp_count;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, abort, gate_ready, exec_done;
  logic [2:0]  prog_id, rom_prog_id;
  logic [7:0]  rom_addr, gate_count;
  logic [31:0] rom_data;
  logic        gate_valid, busy, done, err;
  logic [3:0]  gate_op, gate_qa, gate_qb;
  logic [15:0] gate_imm;
  logic [1:0]  err_code;

  logic [31:0] rom [0:7][0:255];
  gate_t       got_q[$];
  gate_t       exp_q[$];
  int          done_cnt;
  int          n_vec  = 0;
  int          n_miss = 0;
  vec_t        vecs[9];

  assign rom_data = rom[rom_prog_id][rom_addr];

  always #5 clk = ~clk;

  gate_sequencer #(.MAX_QUBITS(MAXQ), .PC_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_id(prog_id), .abort(abort),
    .rom_prog_id(rom_prog_id), .rom_addr(rom_addr), .rom_data(rom_data),
    .gate_valid(gate_valid), .gate_ready(gate_ready), .gate_op(gate_op),
    .gate_qa(gate_qa), .gate_qb(gate_qb), .gate_imm(gate_imm),
    .exec_done(exec_done), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .gate_count(gate_count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int qa, input int qb, input int imm);
    return {4'(op), 4'(qa), 4'(qb), 16'(imm), 4'h0};
  endfunction

  function automatic bit range_bad(input logic [31:0] w);
    int op = int'(w[31:28]);
    int qa = int'(w[27:24]);
    int qb = int'(w[23:20]);
    if (op >= 1 && op <= 3) return qa >= MAXQ;
    if (op >= 4 && op <= 6) return qa >= MAXQ || qb >= MAXQ || qa == qb;
    if (op == 7) return (qa >> MAXQ) != 0 || (qb >> MAXQ) != 0;
    return 1'b0;
  endfunction

  // Walks the program as the programmer sees it: expected gate list and outcome.
  task automatic model(input int pid, output int code);
    int pc = 0;
    logic [31:0] w;
    int op;
    exp_q.delete();
    code = 0;
    forever begin
      w  = rom[pid][pc];
      op = int'(w[31:28]);
      if (op == 15) break;
      if (op >= 8) begin code = 1; break; end
      if (op != 0) begin
        if (range_bad(w)) begin code = 2; break; end
        exp_q.push_back('{w[31:28], w[27:24], w[23:20], w[19:4]});
      end
      if (pc == 255) begin code = 3; break; end
      pc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_prog(input int pid, input int stall_idx, input int stall_len,
                          input int exec_lat, input int abort_gate);
    int    wait_cnt   = 0;
    int    exec_cnt   = 0;
    int    cyc        = 0;
    bit    abort_pend = 1'b0;
    bit    timed_out  = 1'b0;
    gate_t cur, hold;
    got_q.delete();
    done_cnt = 0;
    hold     = '0;
    prog_id  = 3'(pid);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_err_clear", 32'({err, err_code}), 0);
    check("start_count_clear", 32'(gate_count), 0);
    check("rom_prog_id", 32'(rom_prog_id), pid);
    while (busy) begin
      if (cyc == BUDGET) begin timed_out = 1'b1; break; end
      cyc++;
      gate_ready = 1'b0;
      exec_done  = 1'b0;
      abort      = abort_pend;
      abort_pend = 1'b0;
      if (abort) exec_cnt = 0;
      if (done) done_cnt++;
      if (exec_cnt > 0) begin
        exec_cnt--;
        if (exec_cnt == 0) exec_done = 1'b1;
      end
      if (gate_valid) begin
        cur = '{gate_op, gate_qa, gate_qb, gate_imm};
        if (wait_cnt == 0) hold = cur;
        else check("held_while_stalled", 32'(cur), 32'(hold));
        if (got_q.size() != stall_idx || wait_cnt >= stall_len) begin
          gate_ready = 1'b1;
          got_q.push_back(cur);
          wait_cnt = 0;
          exec_cnt = exec_lat;
          if (got_q.size() == abort_gate) abort_pend = 1'b1;
        end else wait_cnt++;
      end
      @(negedge clk);
    end
    gate_ready = 1'b0;
    exec_done  = 1'b0;
    abort      = 1'b0;
    check("run_timeout", 32'(timed_out), 0);
    if (timed_out) do_reset();
  endtask

  task automatic check_run(input int exp_gates, input int exp_done,
                           input int exp_code, input int exp_count);
    int n;
    check("gates_issued", 32'(got_q.size()), exp_gates);
    check("done_pulses", 32'(done_cnt), exp_done);
    check("err", 32'(err), 32'(exp_code != 0));
    check("err_code", 32'(err_code), exp_code);
    check("gate_count", 32'(gate_count), exp_count);
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("gate_fields", 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic wait_valid(output int k);
    k = 1;
    while (!gate_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic start_prog(input int pid);
    prog_id = 3'(pid);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int code, k, n, r;
    rst = 1'b1; start = 1'b0; abort = 1'b0; gate_ready = 1'b0; exec_done = 1'b0;
    prog_id = '0;
    for (int p = 0; p < 8; p++)
      for (int a = 0; a < 256; a++) rom[p][a] = (p == 3) ? mk(1, 0, 0, 0) : mk(15, 0, 0, 0);
    rom[0][0] = mk(0, 0, 0, 0); rom[0][1] = mk(0, 0, 0, 0); rom[0][2] = mk(2, 2, 0, 0);
    rom[1][0] = mk(1, 0, 0, 0); rom[1][1] = mk(9, 0, 0, 0);
    rom[2][0] = mk(4, 5, 0, 0);
    rom[4][0] = mk(1, 0, 0, 0); rom[4][1] = mk(5, 0, 1, 2);
    rom[4][2] = mk(1, 1, 0, 0); rom[4][3] = mk(6, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      rom[5][i]     = mk(1, i, 0, 0);
      rom[5][i + 5] = mk(1, i, 0, 0);
    end
    rom[5][4] = mk(7, 15, 15, 1);
    rom[6][0] = mk(1, 0, 0, 0); rom[6][1] = mk(4, 1, 0, 0);

    repeat (2) @(negedge clk);
    check("reset_outputs",
          32'({rom_prog_id, rom_addr, gate_valid, busy, done, err, err_code, gate_count}), 0);
    check("reset_gate_fields", 32'({gate_op, gate_qa, gate_qb, gate_imm}), 0);
    rst = 1'b0;
    @(negedge clk);

    // pid, stall_idx, stall_len, exec_lat, abort_gate, gates, done, code, count
    vecs[0] = '{6, -1, 0, 3, 0,   2, 1, 0,   2};  // Bell
    vecs[1] = '{4,  1, 5, 2, 0,   4, 1, 0,   4};  // QFT2, 2nd gate stalled
    vecs[2] = '{0, -1, 0, 1, 0,   1, 1, 0,   1};  // NOP NOP X END
    vecs[3] = '{1, -1, 0, 2, 0,   1, 0, 1,   1};  // illegal opcode after one gate
    vecs[4] = '{6, -1, 0, 1, 0,   2, 1, 0,   2};  // restart clears err
    vecs[5] = '{2, -1, 0, 1, 0,   0, 0, 2,   0};  // CNOT qa=5
    vecs[6] = '{3, -1, 0, 1, 0, 256, 0, 3, 255};  // no END: overrun, count saturates
    vecs[7] = '{5, -1, 0, 4, 3,   3, 0, 0,   3};  // Grover abort in 3rd WAIT_EXEC
    vecs[8] = '{5,  0, 2, 1, 0,   9, 1, 0,   9};  // Grover to completion
    foreach (vecs[i]) begin
      model(vecs[i].pid, code);
      run_prog(vecs[i].pid, vecs[i].stall_idx, vecs[i].stall_len, vecs[i].exec_lat,
               vecs[i].abort_gate);
      check("model_outcome", 32'(code), vecs[i].exp_code);
      check_run(vecs[i].exp_gates, vecs[i].exp_done, vecs[i].exp_code, vecs[i].exp_count);
      @(negedge clk);
    end

    // Start-to-valid latency through two NOPs, then abort out of ISSUE.
    start_prog(0);
    wait_valid(k);
    check("nop_stub_latency", 32'(k), 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_issue", 32'({busy, gate_valid, done, err}), 0);

    // Minimum latency, exec_done-to-next-valid, stray exec_done, start while busy.
    start_prog(6);
    wait_valid(k);
    check("start_to_valid", 32'(k), 2);
    prog_id = 3'd0;
    start   = 1'b1;
    gate_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gate_ready = 1'b0;
    check("start_ignored_busy", 32'(rom_prog_id), 6);
    check("valid_low_wait", 32'(gate_valid), 0);
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    check("valid_low_fetch", 32'(gate_valid), 0);
    @(negedge clk);
    check("exec_to_valid", 32'({gate_valid, gate_op, gate_qa, gate_qb}), 32'({1'b1, 12'h410}));
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    check("stray_exec_done", 32'({gate_valid, gate_count}), 32'({1'b1, 8'd1}));

    // Reset while a gate is being offered.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_issue",
          32'({rom_prog_id, rom_addr, gate_valid, busy, done, err, err_code, gate_count}), 0);
    check("rst_gate_fields", 32'({gate_op, gate_qa, gate_qb, gate_imm}), 0);

    // start and abort together in IDLE: start wins.
    prog_id = 3'd6;
    start   = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_beats_abort", 32'(busy), 1);
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_fetch", 32'({busy, gate_valid}), 0);
    @(negedge clk);

    // Randomized programs against the reference walk.
    for (int t = 0; t < 40; t++) begin
      for (int a = 0; a < 256; a++) begin
        r = $urandom_range(0, 99);
        if (r < 7)       rom[7][a] = mk(15, 0, 0, 0);
        else if (r < 15) rom[7][a] = mk(0, $urandom_range(0, 15), 0, 0);
        else if (r < 18) rom[7][a] = mk($urandom_range(8, 14), 0, 0, 0);
        else rom[7][a] = mk($urandom_range(1, 7),
                            ($urandom_range(0, 19) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3),
                            $urandom_range(0, 3), $urandom_range(0, 65535));
      end
      model(7, code);
      n = exp_q.size();
      run_prog(7, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 4), 0);
      check_run(n, (code == 0) ? 1 : 0, code, (n > 255) ? 255 : n);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/gate_sequencer.md
GATE_SEQUENCER -- requirements
Module: gate_sequencer

Interface
REQ-001 Parameter MAX_QUBITS, default 4: number of qubits; any qubit index >= MAX_QUBITS is illegal.
REQ-002 Parameter PC_W, default 8: program counter and microcode address width.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 prog_id  input  3  program select; captured on accepted start.
REQ-007 abort  input  1  cancel a running program.
REQ-008 rom_prog_id  output  3  program select to microcode ROM (captured value).
REQ-009 rom_addr  output  PC_W  microcode address (= pc).
REQ-010 rom_data  input  32  ROM word, combinational from rom_prog_id/rom_addr.
REQ-011 gate_valid  output  1  gate command valid.
REQ-012 gate_ready  input  1  datapath accepts command.
REQ-013 gate_op / gate_qa / gate_qb  output  4/4/4  opcode, target (or mask), control (or value).
REQ-014 gate_imm  output  16  immediate (word bits [19:4]).
REQ-015 exec_done  input  1  one-cycle pulse: datapath finished the accepted gate.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse on normal END completion.
REQ-018 err  output  1  program terminated on error; held until next accepted start or rst.
REQ-019 err_code  output  2  0 none, 1 illegal opcode, 2 qubit out of range, 3 pc overrun.
REQ-020 gate_count  output  8  gates accepted in current/last run; saturates at 255.

Function
REQ-021 Word fields: [31:28] op, [27:24] qa, [23:20] qb, [19:4] imm. Opcodes: 0 NOP, 1 H, 2 X, 3 Z, 4 CNOT, 5 CPHASE, 6 SWAP, 7 MASKPHASE, 15 END; 8-14 illegal.
REQ-022 States: IDLE, FETCH, ISSUE, WAIT_EXEC, DONE, ERROR.
REQ-023 IDLE & start: capture prog_id; pc<=0; gate_count<=0; err<=0; err_code<=0; go FETCH next cycle.
REQ-024 FETCH (one cycle): register rom_data into instruction register, decode, then: END -> DONE; NOP -> pc+1, stay FETCH; illegal op -> ERROR(1); range fault -> ERROR(2); else -> ISSUE.
REQ-025 Range check: ops 1-3 check qa; ops 4-6 check qa and qb, and qa==qb is error 2; op 7 checks that mask/value bits at or above MAX_QUBITS are zero.
REQ-026 ISSUE: gate_valid=1; gate_* fields from instruction register, stable while valid && !ready; on gate_ready go WAIT_EXEC and increment gate_count.
REQ-027 WAIT_EXEC: exec_done is sampled only in this state; on exec_done, pc+1 and go FETCH. exec_done in any other state is ignored.
REQ-028 Incrementing pc from all-ones (instruction without END at last address) -> ERROR(3); pc never wraps.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE.
REQ-030 ERROR: one cycle, set err/err_code, then IDLE; done is not pulsed.
REQ-031 abort in FETCH/ISSUE/WAIT_EXEC: IDLE next cycle, gate_valid low from next cycle, no done, no err; abort has priority over every other transition in the same cycle.
REQ-032 start while busy is ignored; start and abort together in IDLE: start wins.
REQ-033 Minimum latency: start at cycle N -> gate_valid at N+2; exec_done at M -> next gate_valid at M+2.
REQ-034 gate_valid is 0 in all states except ISSUE.

Reset
REQ-035 rst has priority over all inputs: state IDLE, pc 0, captured prog_id 0, gate_valid/busy/done/err 0, err_code 0, gate_count 0, gate fields 0.
REQ-036 rst mid-run drops gate_valid in the next cycle; no done or err pulse is emitted.

Structure
REQ-037 Shared package qc_pkg holds the opcode enum, err_code enum, sequencer state enum and packed instruction struct.
REQ-038 Decode and range check are a sub-module, gate_decoder (combinational: instruction in; kind {exec, nop, end, illegal, range_err} out).

Verification
REQ-039 Bell (prog 6), gate_ready=1, exec_done 3 cycles after each accept -> H qa=0, then CNOT qa=1 qb=0; one done; gate_count=2; err=0.
REQ-040 QFT2 with gate_ready low for 5 cycles on 2nd gate -> CPHASE qa=0 qb=1 imm=0x0002 held stable for all 5 cycles; 4 gates total, then done.
REQ-041 Stub ROM: NOP, NOP, X q2, END -> single X issued; gate_valid first seen 4 cycles after start; gate_count=1.
REQ-042 Stub ROM word op=9 at addr 1 -> after first gate, err=1, err_code=1, no done; next start clears err.
REQ-043 Stub ROM: CNOT qa=5 -> err_code=2, no gate issued; stub ROM with no END (all H q0) -> 256 gates, then err_code=3.
REQ-044 Grover4 abort asserted in WAIT_EXEC of 3rd gate -> IDLE next cycle, busy=0, gate_count=3, no done; rst mid-ISSUE -> all outputs 0 next cycle.
